// File: rtl/logic_op_arbiter.sv
// Round-robin shared evaluator of Verilog logical ops (!, &&, ||) on dual-rail 4-state operands.
// One-entry result buffer with valid/ready on both sides; saturating per-requester handoff counters.
module logic_op_arbiter #(
  parameter int W1    = 3,
  parameter int W2    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [W1-1:0]    a_val1,
  input  logic [W1-1:0]    a_x1,
  input  logic [W2-1:0]    a_val2,
  input  logic [W2-1:0]    a_x2,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [W1-1:0]    b_val1,
  input  logic [W1-1:0]    b_x1,
  input  logic [W2-1:0]    b_val2,
  input  logic [W2-1:0]    b_x2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_val,
  output logic             res_x,
  output logic             res_id,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;        // 1: B has priority on the next tie
  logic             res_val_q, res_val_d;
  logic             res_x_q, res_x_d;
  logic             res_id_q, res_id_d;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  logic          can_accept, grant_a, grant_b, accept, handoff;
  logic [1:0]    sel_op;
  logic [W1-1:0] sel_val1, sel_x1;
  logic [W2-1:0] sel_val2, sel_x2;
  logic          t1, f1, t2, f2;
  logic          new_val, new_x;

  always_comb begin
    can_accept = (state_q == EMPTY) || res_ready;
    grant_a    = !rst && can_accept && a_valid && (!b_valid || !ptr_q);
    grant_b    = !rst && can_accept && b_valid && (!a_valid || ptr_q);
    accept     = grant_a || grant_b;
    handoff    = (state_q == FULL) && res_ready;

    sel_op   = grant_b ? b_op   : a_op;
    sel_val1 = grant_b ? b_val1 : a_val1;
    sel_x1   = grant_b ? b_x1   : a_x1;
    sel_val2 = grant_b ? b_val2 : a_val2;
    sel_x2   = grant_b ? b_x2   : a_x2;

    // An operand is TRUE on any known 1, FALSE only when fully known and all 0.
    t1 = |(sel_val1 & ~sel_x1);
    f1 = ~|(sel_val1 | sel_x1);
    t2 = |(sel_val2 & ~sel_x2);
    f2 = ~|(sel_val2 | sel_x2);

    new_val = 1'b0;
    new_x   = 1'b0;
    case (sel_op)
      2'b00: begin
        new_val = f1;
        new_x   = !t1 && !f1;
      end
      2'b01: begin
        new_val = f2;
        new_x   = !t2 && !f2;
      end
      2'b10: begin
        new_val = !(f1 || f2) && t1 && t2;
        new_x   = !(f1 || f2) && !(t1 && t2);
      end
      default: begin
        new_val = t1 || t2;
        new_x   = !(t1 || t2) && !(f1 && f2);
      end
    endcase

    state_d   = state_q;
    if (accept)
      state_d = FULL;
    else if (handoff)
      state_d = EMPTY;

    ptr_d     = accept ? grant_a : ptr_q;
    res_val_d = accept ? new_val : res_val_q;
    res_x_d   = accept ? new_x   : res_x_q;
    res_id_d  = accept ? grant_b : res_id_q;

    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (handoff && !res_id_q && (a_count_q != {CNT_W{1'b1}}))
      a_count_d = a_count_q + CNT_W'(1);
    if (handoff && res_id_q && (b_count_q != {CNT_W{1'b1}}))
      b_count_d = b_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      ptr_q     <= 1'b0;
      res_val_q <= 1'b0;
      res_x_q   <= 1'b0;
      res_id_q  <= 1'b0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      res_val_q <= res_val_d;
      res_x_q   <= res_x_d;
      res_id_q  <= res_id_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign res_valid = (state_q == FULL);
  assign res_val   = res_val_q;
  assign res_x     = res_x_q;
  assign res_id    = res_id_q;
  assign a_count   = a_count_q;
  assign b_count   = b_count_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: Kleene-logic reference model checked every cycle, directed literal
// cases, randomized traffic, and a second CNT_W=2 instance sharing the stimulus for saturation.
module tb_logic_op_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, res_ready = 1'b1;
  logic [1:0] a_op = 2'b00, b_op = 2'b00;
  logic [2:0] a_val1 = '0, a_x1 = '0, b_val1 = '0, b_x1 = '0;
  logic [3:0] a_val2 = '0, a_x2 = '0, b_val2 = '0, b_x2 = '0;

  logic        a_ready, b_ready, res_valid, res_val, res_x, res_id;
  logic [15:0] a_count, b_count;
  logic        s_a_ready, s_b_ready, s_res_valid, s_res_val, s_res_x, s_res_id;
  logic [1:0]  s_a_count, s_b_count;

  always #5 clk = ~clk;

  logic_op_arbiter #(.W1(3), .W2(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_val1(a_val1), .a_x1(a_x1),
    .a_val2(a_val2), .a_x2(a_x2),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_val1(b_val1), .b_x1(b_x1),
    .b_val2(b_val2), .b_x2(b_x2),
    .res_valid(res_valid), .res_ready(res_ready), .res_val(res_val), .res_x(res_x),
    .res_id(res_id), .a_count(a_count), .b_count(b_count)
  );

  logic_op_arbiter #(.W1(3), .W2(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_op(a_op), .a_val1(a_val1), .a_x1(a_x1),
    .a_val2(a_val2), .a_x2(a_x2),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_op(b_op), .b_val1(b_val1), .b_x1(b_x1),
    .b_val2(b_val2), .b_x2(b_x2),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_val(s_res_val), .res_x(s_res_x),
    .res_id(s_res_id), .a_count(s_a_count), .b_count(s_b_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Truth levels: 0 = FALSE, 1 = UNKNOWN, 2 = TRUE. && is min, || is max, ! is 2-t.
  function automatic int truth(input logic [3:0] v, input logic [3:0] x, input int w);
    bit has_t = 0, has_x = 0;
    for (int i = 0; i < w; i++) begin
      if (x[i]) has_x = 1;
      else if (v[i]) has_t = 1;
    end
    if (has_t) return 2;
    if (has_x) return 1;
    return 0;
  endfunction

  function automatic int kleene(input logic [1:0] op, input int t1, input int t2);
    case (op)
      2'b00:   return 2 - t1;
      2'b01:   return 2 - t2;
      2'b10:   return (t1 < t2) ? t1 : t2;
      default: return (t1 > t2) ? t1 : t2;
    endcase
  endfunction

  // Reference model state
  bit m_full, m_val, m_x, m_id, m_last_b, m_fresh, chk_en;
  int m_cnt_a, m_cnt_b;
  bit m_can, m_ga, m_gb, m_hand;
  int m_t;

  initial begin
    chk_en = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_full = 0; m_val = 0; m_x = 0; m_id = 0; m_last_b = 1; m_fresh = 1;
        m_cnt_a = 0; m_cnt_b = 0; chk_en = 1;
      end else begin
        m_hand = m_full && res_ready;
        if (m_hand) begin
          if (m_id) begin if (m_cnt_b < 65535) m_cnt_b++; end
          else begin if (m_cnt_a < 65535) m_cnt_a++; end
        end
        m_can = !m_full || res_ready;
        m_ga  = m_can && a_valid && (!b_valid || m_last_b);
        m_gb  = m_can && b_valid && (!a_valid || !m_last_b);
        if (m_ga || m_gb) begin
          if (m_ga) m_t = kleene(a_op, truth({1'b0, a_val1}, {1'b0, a_x1}, 3), truth(a_val2, a_x2, 4));
          else      m_t = kleene(b_op, truth({1'b0, b_val1}, {1'b0, b_x1}, 3), truth(b_val2, b_x2, 4));
          m_full = 1; m_val = (m_t == 2); m_x = (m_t == 1); m_id = m_gb; m_last_b = m_gb; m_fresh = 0;
        end else if (m_hand) begin
          m_full = 0;
        end
      end
    end
  end

  bit e_can, e_a, e_b;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_can = !m_full || res_ready;
        e_a   = !rst && e_can && a_valid && (!b_valid || m_last_b);
        e_b   = !rst && e_can && b_valid && (!a_valid || !m_last_b);
        check("mdl a_ready", a_ready, e_a);
        check("mdl b_ready", b_ready, e_b);
        check("mdl res_valid", res_valid, m_full);
        if (m_full || m_fresh) begin
          check("mdl res_val", res_val, m_val);
          check("mdl res_x", res_x, m_x);
          check("mdl res_id", res_id, m_id);
        end
        check("mdl a_count", a_count, m_cnt_a);
        check("mdl b_count", b_count, m_cnt_b);
        check("sat a_ready", s_a_ready, e_a);
        check("sat b_ready", s_b_ready, e_b);
        check("sat res_valid", s_res_valid, m_full);
        check("sat a_count", s_a_count, (m_cnt_a > 3) ? 3 : m_cnt_a);
        check("sat b_count", s_b_count, (m_cnt_b > 3) ? 3 : m_cnt_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // Single A op with res_ready=1: accepted immediately, result visible next cycle, then handed off.
  task automatic a_single(input string name, input logic [1:0] op, input logic [2:0] v1,
                          input logic [2:0] x1, input logic [3:0] v2, input logic [3:0] x2,
                          input logic ev, input logic ex);
    a_op = op; a_val1 = v1; a_x1 = x1; a_val2 = v2; a_x2 = x2; a_valid = 1;
    @(negedge clk);
    check({name, " a_ready"}, a_ready, 1);
    tick();
    a_valid = 0;
    @(negedge clk);
    check({name, " res_valid"}, res_valid, 1);
    check({name, " res_val"}, res_val, ev);
    check({name, " res_x"}, res_x, ex);
    check({name, " res_id"}, res_id, 0);
    tick();
  endtask

  int a_rem, b_rem;
  bit acc_a, acc_b;

  initial begin
    // Reset state with A requesting: no ready during reset
    a_valid = 1;
    tick();
    @(negedge clk);
    check("rst a_ready", a_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst a_count", a_count, 0);
    tick();
    rst = 0; a_valid = 0;

    a_single("t1 not111", 2'b00, 3'b111, 3'b000, 4'b0000, 4'b0000, 0, 0);
    a_single("t2 not0000", 2'b01, 3'b111, 3'b000, 4'b0000, 4'b0000, 1, 0);
    a_single("t2 and", 2'b10, 3'b111, 3'b000, 4'b0000, 4'b0000, 0, 0);
    a_single("t2 or", 2'b11, 3'b111, 3'b000, 4'b0000, 4'b0000, 1, 0);
    @(negedge clk);
    check("t2 a_count", a_count, 4);
    tick();

    a_single("t3 notx", 2'b00, 3'b000, 3'b001, 4'b0000, 4'b0000, 0, 1);
    a_single("t3 orx", 2'b11, 3'b000, 3'b001, 4'b0000, 4'b0000, 0, 1);
    a_single("t3 andfalse", 2'b10, 3'b000, 3'b001, 4'b0000, 4'b0000, 0, 0);
    a_single("t3 ortrue", 2'b11, 3'b100, 3'b001, 4'b0000, 4'b0000, 1, 0);

    // Both requesters contending: strict alternation starting with A, no idle cycles
    do_reset();
    a_op = 2'b00; a_val1 = 3'b111; a_x1 = 3'b000;
    b_op = 2'b01; b_val2 = 4'b0000; b_x2 = 4'b0000;
    a_valid = 1; b_valid = 1; a_rem = 4; b_rem = 4;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      check("t4 a_grant", a_ready, (s % 2) == 0);
      check("t4 b_grant", b_ready, (s % 2) == 1);
      if (a_ready) a_rem--;
      if (b_ready) b_rem--;
      tick();
      a_valid = (a_rem > 0); b_valid = (b_rem > 0);
    end
    a_valid = 0; b_valid = 0;
    tick();
    @(negedge clk);
    check("t4 a_count", a_count, 4);
    check("t4 b_count", b_count, 4);
    check("t4 sat a_count", s_a_count, 3);
    check("t4 sat b_count", s_b_count, 3);
    tick();

    // Backpressure: result held, no readies, then same-cycle accept once released
    res_ready = 0;
    a_op = 2'b11; a_val1 = 3'b100; a_x1 = 3'b001; a_valid = 1;
    tick();
    a_op = 2'b00; a_val1 = 3'b111; a_x1 = 3'b000; b_valid = 1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("t5 a_ready", a_ready, 0);
      check("t5 b_ready", b_ready, 0);
      check("t5 res_valid", res_valid, 1);
      check("t5 res_val", res_val, 1);
      check("t5 res_x", res_x, 0);
      check("t5 res_id", res_id, 0);
      tick();
    end
    res_ready = 1;
    @(negedge clk);
    check("t5 release b_ready", b_ready, 1);
    check("t5 release a_ready", a_ready, 0);
    tick();
    b_valid = 0;
    @(negedge clk);
    check("t5 b res_id", res_id, 1);
    check("t5 b res_val", res_val, 1);
    tick();
    a_valid = 0;
    tick();

    // Reset while FULL discards the result and clears counters; A wins the first tie
    res_ready = 0; a_valid = 1;
    tick();
    a_valid = 1; b_valid = 1; rst = 1;
    @(negedge clk);
    check("t6 rst a_ready", a_ready, 0);
    check("t6 rst b_ready", b_ready, 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("t6 res_valid", res_valid, 0);
    check("t6 a_count", a_count, 0);
    check("t6 b_count", b_count, 0);
    check("t6 tie a_ready", a_ready, 1);
    check("t6 tie b_ready", b_ready, 0);
    tick();
    a_valid = 0; b_valid = 0; res_ready = 1;
    tick();

    // Randomized traffic; payloads are held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (!a_valid || acc_a || rst) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_op    = 2'($urandom);
        a_val1  = ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'b000;
        a_x1    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        a_val2  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
        a_x2    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end
      if (!b_valid || acc_b || rst) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_op    = 2'($urandom);
        b_val1  = ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'b000;
        b_x1    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        b_val2  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
        b_x2    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    rst = 0; a_valid = 0; b_valid = 0; res_ready = 1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
